// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter
// Priority arbiter for a small DMA controller. Combines raw DREQ pins (with
// programmable polarity and masking) and software requests, selects a winner
// (fixed or rotating priority), runs the HRQ/HLDA handshake with the CPU and
// drives one-hot DACK with programmable polarity.
// Optional feature: define DMA_ARB_DREQ_SYNC_EN to pass dreq through a
// two-flop synchronizer (two extra cycles of request latency).
module dma_priority_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_dreq,
    input  logic              i_dreq_sense,
    input  logic              i_dack_sense,
    input  logic [NUM_CH-1:0] i_mask_register,
    input  logic [NUM_CH-1:0] i_request_register,
    input  logic              i_rotating_priority,
    input  logic              i_enable,
    input  logic              i_hlda,
    input  logic              i_tc,
    input  logic              i_release,
    output logic              o_hrq,
    output logic [NUM_CH-1:0] o_dack,
    output logic              o_grant_valid,
    output logic [CH_W-1:0]   o_channel_no,
    output logic [NUM_CH-1:0] o_status_req
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_hrq;
    logic              r_grant_valid;
    logic [CH_W-1:0]   r_channel_no;
    logic [CH_W-1:0]   r_top_pri;
    logic [NUM_CH-1:0] r_status_req;
    logic [NUM_CH-1:0] r_dack;
    // Holds the arbiter in IDLE for one extra cycle after any return to IDLE,
    // so a new HRQ never follows a completion sooner than two cycles later.
    logic              r_cool;

    logic [NUM_CH-1:0] w_dreq;
    logic [NUM_CH-1:0] w_eff_req;
    logic [CH_W-1:0]   w_search_start;
    logic [CH_W-1:0]   w_winner;
    logic [NUM_CH-1:0] w_onehot;
    logic              w_cur_req;
    logic [NUM_CH-1:0] w_dack_act;
    logic [NUM_CH-1:0] w_dack_idle;
    logic [CH_W-1:0]   w_next_top;
    logic [CH_W:0]     w_next_sum;

    // First set bit of req searching upward from start with wrap-around.
    function automatic logic [CH_W-1:0] f_pick(input logic [NUM_CH-1:0] req,
                                               input logic [CH_W-1:0]   start);
        logic [2*NUM_CH-1:0] rot;
        logic [2*NUM_CH-1:0] tmp;
        logic [CH_W-1:0]     off;
        logic [CH_W:0]       sum;
        rot = {req, req} >> start;
        off = {CH_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            tmp = rot >> i;
            if (tmp[0]) begin
                off = CH_W'(i);
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (CH_W+1)'(NUM_CH)) begin
            sum = sum - (CH_W+1)'(NUM_CH);
        end
        return sum[CH_W-1:0];
    endfunction

`ifdef DMA_ARB_DREQ_SYNC_EN
    logic [NUM_CH-1:0] r_dreq_s1;
    logic [NUM_CH-1:0] r_dreq_s2;

    // Two-flop synchronizer for the asynchronous DREQ pins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dreq_s1 <= {NUM_CH{1'b0}};
            r_dreq_s2 <= {NUM_CH{1'b0}};
        end else begin
            r_dreq_s1 <= i_dreq;
            r_dreq_s2 <= r_dreq_s1;
        end
    end

    assign w_dreq = r_dreq_s2;
`else
    assign w_dreq = i_dreq;
`endif

    assign w_eff_req      = ((w_dreq ^ {NUM_CH{i_dreq_sense}}) & ~i_mask_register)
                            | i_request_register;
    assign w_search_start = i_rotating_priority ? r_top_pri : {CH_W{1'b0}};
    assign w_winner       = f_pick(w_eff_req, w_search_start);
    assign w_onehot       = {{(NUM_CH-1){1'b0}}, 1'b1} << r_channel_no;
    assign w_cur_req      = |(w_eff_req & w_onehot);
    assign w_dack_act     = i_dack_sense ? w_onehot : ~w_onehot;
    assign w_dack_idle    = {NUM_CH{~i_dack_sense}};
    assign w_next_sum     = {1'b0, r_channel_no} + (CH_W+1)'(1);

    // Rotating pointer after completion: channel just served moves to lowest priority.
    always_comb begin
        w_next_top = w_next_sum[CH_W-1:0];
        if (w_next_sum >= (CH_W+1)'(NUM_CH)) begin
            w_next_top = {CH_W{1'b0}};
        end else begin
            w_next_top = w_next_sum[CH_W-1:0];
        end
    end

    // Arbitration FSM with registered handshake, grant and status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_hrq         <= 1'b0;
            r_grant_valid <= 1'b0;
            r_channel_no  <= {CH_W{1'b0}};
            r_top_pri     <= {CH_W{1'b0}};
            r_status_req  <= {NUM_CH{1'b0}};
            r_dack        <= w_dack_idle;
            r_cool        <= 1'b0;
        end else begin
            r_status_req <= w_eff_req;
            case (r_state)
                ST_IDLE: begin
                    r_grant_valid <= 1'b0;
                    r_dack        <= w_dack_idle;
                    if (r_cool) begin
                        r_cool <= 1'b0;
                        r_hrq  <= 1'b0;
                    end else if (i_enable && (w_eff_req != {NUM_CH{1'b0}})) begin
                        r_state      <= ST_REQ;
                        r_channel_no <= w_winner;
                        r_hrq        <= 1'b1;
                    end else begin
                        r_hrq <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (i_hlda) begin
                        r_state       <= ST_SERVICE;
                        r_grant_valid <= 1'b1;
                        r_dack        <= w_dack_act;
                    end else if (!w_cur_req || !i_enable) begin
                        r_state       <= ST_IDLE;
                        r_hrq         <= 1'b0;
                        r_grant_valid <= 1'b0;
                        r_dack        <= w_dack_idle;
                        r_cool        <= 1'b1;
                    end else begin
                        r_dack <= w_dack_idle;
                    end
                end
                ST_SERVICE: begin
                    if (!i_hlda) begin
                        // CPU took the bus back: abort without rotating priority.
                        r_state       <= ST_IDLE;
                        r_hrq         <= 1'b0;
                        r_grant_valid <= 1'b0;
                        r_dack        <= w_dack_idle;
                        r_cool        <= 1'b1;
                    end else if (i_tc || i_release) begin
                        r_state       <= ST_IDLE;
                        r_hrq         <= 1'b0;
                        r_grant_valid <= 1'b0;
                        r_dack        <= w_dack_idle;
                        r_cool        <= 1'b1;
                        if (i_rotating_priority) begin
                            r_top_pri <= w_next_top;
                        end
                    end else begin
                        r_dack <= w_dack_act;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_hrq         <= 1'b0;
                    r_grant_valid <= 1'b0;
                    r_dack        <= w_dack_idle;
                    r_cool        <= 1'b1;
                end
            endcase
        end
    end

    assign o_hrq         = r_hrq;
    assign o_dack        = r_dack;
    assign o_grant_valid = r_grant_valid;
    assign o_channel_no  = r_channel_no;
    assign o_status_req  = r_status_req;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter (NUM_CH = 4).
// Expected winning channels are queued when requests are driven and
// compared when the DUT raises hrq.
module tb_dma_priority_arbiter;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
`ifdef DMA_ARB_DREQ_SYNC_EN
    localparam int DLAT = 2;
`else
    localparam int DLAT = 0;
`endif

    logic              clk;
    logic              rst;
    logic [NUM_CH-1:0] dreq;
    logic              dreq_sense;
    logic              dack_sense;
    logic [NUM_CH-1:0] mask_reg;
    logic [NUM_CH-1:0] req_reg;
    logic              rot;
    logic              enable;
    logic              hlda;
    logic              tc;
    logic              rel;
    logic              hrq;
    logic [NUM_CH-1:0] dack;
    logic              grant_valid;
    logic [CH_W-1:0]   channel_no;
    logic [NUM_CH-1:0] status_req;

    int n_pass  = 0;
    int n_total = 0;
    logic [CH_W-1:0] exp_q[$];

    dma_priority_arbiter #(.NUM_CH(NUM_CH)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_dreq              (dreq),
        .i_dreq_sense        (dreq_sense),
        .i_dack_sense        (dack_sense),
        .i_mask_register     (mask_reg),
        .i_request_register  (req_reg),
        .i_rotating_priority (rot),
        .i_enable            (enable),
        .i_hlda              (hlda),
        .i_tc                (tc),
        .i_release           (rel),
        .o_hrq               (hrq),
        .o_dack              (dack),
        .o_grant_valid       (grant_valid),
        .o_channel_no        (channel_no),
        .o_status_req        (status_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        dreq = 4'b0000;
        repeat (n) tick();
    endtask

    // Waits (bounded) for hrq and compares channelNo against the scoreboard.
    task automatic expect_grant(output bit ok);
        logic [CH_W-1:0] ch;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (hrq === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty: got empty queue, required an entry");
        end else begin
            ch = exp_q.pop_front();
            if (!ok) $display("FAIL hrq_timeout: got hrq=0 for 20 cycles, required 1 (ch %0d)", ch);
            else if (channel_no !== ch) $display("FAIL channel_no: got %0d, required %0d", channel_no, ch);
            else n_pass++;
        end
    endtask

    // Serves the pending grant: hlda after hlda_delay cycles, then completes.
    task automatic serve(input int hlda_delay, input logic [3:0] dreq_after, input bit by_tc);
        bit ok;
        logic [3:0] exp_dack;
        exp_dack = (exp_q.size() != 0) ? ~(4'b0001 << exp_q[0]) : 4'b1111;
        expect_grant(ok);
        if (ok) begin
            n_total++;
            if (dack !== 4'b1111) $display("FAIL dack_pending: got %b, required 1111", dack);
            else n_pass++;
            repeat (hlda_delay) tick();
            hlda = 1'b1;
            tick();
            n_total++;
            if (grant_valid !== 1'b1 || dack !== exp_dack)
                $display("FAIL service: got gv=%b dack=%b, required gv=1 dack=%b", grant_valid, dack, exp_dack);
            else n_pass++;
            if (by_tc) tc = 1'b1;
            else rel = 1'b1;
            dreq = dreq_after;
            tick();
            tc = 1'b0;
            rel = 1'b0;
            hlda = 1'b0;
            n_total++;
            if (hrq !== 1'b0 || grant_valid !== 1'b0 || dack !== 4'b1111)
                $display("FAIL completion: got hrq=%b gv=%b dack=%b, required 0 0 1111", hrq, grant_valid, dack);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dreq = 4'b1111;
        repeat (2) tick();
        n_total++;
        if (hrq !== 1'b0 || grant_valid !== 1'b0 || channel_no !== 2'd0 || dack !== 4'b1111 || status_req !== 4'b0000)
            $display("FAIL reset: got hrq=%b gv=%b ch=%0d dack=%b st=%b, required 0 0 0 1111 0000",
                     hrq, grant_valid, channel_no, dack, status_req);
        else n_pass++;
        dreq = 4'b0000;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        bit ok;
        dreq = 4'b0001;
        exp_q.push_back(2'd0);
        n_total++;
        if (hrq !== 1'b0) $display("FAIL latency_pre: got hrq=%b, required 0", hrq);
        else n_pass++;
        repeat (DLAT + 1) tick();
        n_total++;
        if (hrq !== 1'b1) $display("FAIL latency: got hrq=%b, required 1 after %0d cycles", hrq, DLAT + 1);
        else n_pass++;
        expect_grant(ok);
        n_total++;
        if (status_req !== 4'b0001) $display("FAIL status_req: got %b, required 0001", status_req);
        else n_pass++;
        idle(DLAT + 4);
    endtask

    task automatic test_fixed();
        rot = 1'b0;
        dreq = 4'b1010;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        serve(3, 4'b1000, 1'b0);
        tick();
        n_total++;
        if (hrq !== 1'b0) $display("FAIL cooldown: got hrq=%b one cycle after completion, required 0", hrq);
        else n_pass++;
        serve(3, 4'b0000, 1'b0);
        idle(DLAT + 3);
    endtask

    task automatic test_mask();
        bit ok;
        mask_reg = 4'b0001;
        dreq = 4'b0001;
        repeat (DLAT + 5) tick();
        n_total++;
        if (hrq !== 1'b0 || status_req !== 4'b0000)
            $display("FAIL masked: got hrq=%b st=%b, required 0 0000", hrq, status_req);
        else n_pass++;
        req_reg = 4'b0001;
        exp_q.push_back(2'd0);
        tick();
        n_total++;
        if (hrq !== 1'b1) $display("FAIL swreq: got hrq=%b, required 1", hrq);
        else n_pass++;
        expect_grant(ok);
        req_reg = 4'b0000;
        mask_reg = 4'b0000;
        idle(DLAT + 4);
    endtask

    task automatic test_withdraw();
        bit ok;
        dreq = 4'b0100;
        exp_q.push_back(2'd2);
        expect_grant(ok);
        dreq = 4'b0000;
        repeat (DLAT + 1) tick();
        n_total++;
        if (hrq !== 1'b0 || dack !== 4'b1111)
            $display("FAIL withdraw: got hrq=%b dack=%b, required 0 1111", hrq, dack);
        else n_pass++;
        idle(3);
        dreq = 4'b0001;
        exp_q.push_back(2'd0);
        expect_grant(ok);
        enable = 1'b0;
        tick();
        n_total++;
        if (hrq !== 1'b0) $display("FAIL disable_in_req: got hrq=%b, required 0", hrq);
        else n_pass++;
        enable = 1'b1;
        idle(DLAT + 4);
    endtask

    task automatic test_enable_in_service();
        bit ok;
        dreq = 4'b0100;
        exp_q.push_back(2'd2);
        expect_grant(ok);
        hlda = 1'b1;
        tick();
        enable = 1'b0;
        repeat (2) tick();
        n_total++;
        if (grant_valid !== 1'b1 || dack !== 4'b1011 || hrq !== 1'b1)
            $display("FAIL disable_in_service: got gv=%b dack=%b hrq=%b, required 1 1011 1", grant_valid, dack, hrq);
        else n_pass++;
        tc = 1'b1;
        dreq = 4'b0000;
        tick();
        tc = 1'b0;
        hlda = 1'b0;
        n_total++;
        if (grant_valid !== 1'b0 || hrq !== 1'b0 || dack !== 4'b1111)
            $display("FAIL tc_complete: got gv=%b hrq=%b dack=%b, required 0 0 1111", grant_valid, hrq, dack);
        else n_pass++;
        enable = 1'b1;
        idle(DLAT + 4);
    endtask

    task automatic test_rotating();
        rot = 1'b1;
        dreq = 4'b0100;
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        serve(1, 4'b1111, 1'b0);
        serve(1, 4'b1111, 1'b1);
        serve(1, 4'b1111, 1'b0);
        serve(1, 4'b0000, 1'b0);
        idle(DLAT + 4);
    endtask

    task automatic test_abort();
        bit ok;
        dreq = 4'b1111;
        exp_q.push_back(2'd2);
        expect_grant(ok);
        hlda = 1'b1;
        tick();
        hlda = 1'b0;
        tick();
        n_total++;
        if (grant_valid !== 1'b0 || hrq !== 1'b0 || dack !== 4'b1111)
            $display("FAIL abort: got gv=%b hrq=%b dack=%b, required 0 0 1111", grant_valid, hrq, dack);
        else n_pass++;
    endtask

    task automatic test_reset_mid_service();
        bit ok;
        exp_q.push_back(2'd2);
        expect_grant(ok);
        hlda = 1'b1;
        tick();
        n_total++;
        if (dack !== 4'b1011) $display("FAIL pre_reset_service: got dack=%b, required 1011", dack);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_total++;
        if (hrq !== 1'b0 || dack !== 4'b1111 || grant_valid !== 1'b0 || channel_no !== 2'd0)
            $display("FAIL reset_mid: got hrq=%b dack=%b gv=%b ch=%0d, required 0 1111 0 0", hrq, dack, grant_valid, channel_no);
        else n_pass++;
        rst = 1'b0;
        hlda = 1'b0;
        exp_q.push_back(2'd0);
        serve(0, 4'b0000, 1'b0);
        rot = 1'b0;
        idle(DLAT + 4);
    endtask

    task automatic test_polarity();
        dack_sense = 1'b1;
        tick();
        n_total++;
        if (dack !== 4'b0000) $display("FAIL dack_idle_high: got %b, required 0000", dack);
        else n_pass++;
        dreq_sense = 1'b1;
        dreq = 4'b1101;
        exp_q.push_back(2'd1);
        begin
            bit ok;
            expect_grant(ok);
        end
        hlda = 1'b1;
        tick();
        n_total++;
        if (dack !== 4'b0010) $display("FAIL dack_active_high: got %b, required 0010", dack);
        else n_pass++;
        rel = 1'b1;
        dreq = 4'b1111;
        tick();
        rel = 1'b0;
        hlda = 1'b0;
        n_total++;
        if (dack !== 4'b0000 || hrq !== 1'b0) $display("FAIL polarity_done: got dack=%b hrq=%b, required 0000 0", dack, hrq);
        else n_pass++;
        dreq_sense = 1'b0;
        dack_sense = 1'b0;
        idle(DLAT + 4);
    endtask

    initial begin
        rst = 1'b1; dreq = 4'b0000; dreq_sense = 1'b0; dack_sense = 1'b0;
        mask_reg = 4'b0000; req_reg = 4'b0000; rot = 1'b0; enable = 1'b1;
        hlda = 1'b0; tc = 1'b0; rel = 1'b0;
        test_reset();
        test_latency();
        test_fixed();
        test_mask();
        test_withdraw();
        test_enable_in_service();
        test_rotating();
        test_abort();
        test_reset_mid_service();
        test_polarity();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dma_priority_arbiter.md
DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, legal 2..8; number of DMA channels.
REQ-002 SHALL have derived parameter CH_W = $clog2(NUM_CH); width of the channel number.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 dreq  in  NUM_CH  raw channel DMA request pins.
REQ-006 dreqSense  in  1  0 = DREQ active-high, 1 = DREQ active-low.
REQ-007 dackSense  in  1  0 = DACK active-low, 1 = DACK active-high.
REQ-008 maskRegister  in  NUM_CH  1 = hardware request of that channel masked.
REQ-009 requestRegister  in  NUM_CH  software requests; not maskable.
REQ-010 RotatingPriority  in  1  1 = rotating priority, 0 = fixed (channel 0 highest).
REQ-011 enable  in  1  controller enable.
REQ-012 hlda  in  1  hold acknowledge from CPU.
REQ-013 TC  in  1  terminal count of the channel in service.
REQ-014 release  in  1  end of service for the current grant.
REQ-015 hrq  out  1  hold request to CPU.
REQ-016 dack  out  NUM_CH  channel acknowledges, polarity per dackSense.
REQ-017 grantValid  out  1  a channel is in service.
REQ-018 channelNo  out  CH_W  channel in service or pending.
REQ-019 statusReq  out  NUM_CH  registered effective request vector.

Function
REQ-020 Effective request vector effReq SHALL be ((dreq XOR {NUM_CH{dreqSense}}) AND NOT maskRegister) OR requestRegister.
REQ-021 FSM SHALL have states IDLE, REQ, SERVICE; reset state IDLE.
REQ-022 IDLE->REQ when enable=1 and effReq!=0; the winning channel SHALL be latched into channelNo on this transition; hrq=1 from the next cycle.
REQ-023 Fixed mode winner: lowest-index set bit of effReq.
REQ-024 Rotating mode winner: first set bit searching upward, with wrap, from pointer topPri (reset 0).
REQ-025 REQ->SERVICE on hlda=1; dack of channelNo active and grantValid=1 from the following cycle.
REQ-026 REQ->IDLE, with hrq=0 next cycle, if effReq[channelNo] drops or enable=0 before hlda=1.
REQ-027 SERVICE->IDLE on TC=1 or release=1 (both together = one completion); next cycle hrq=0, grantValid=0, dack all inactive.
REQ-028 On completion with RotatingPriority=1, topPri SHALL become (channelNo+1) mod NUM_CH; no update in fixed mode.
REQ-029 SERVICE->IDLE on hlda=0 (abort); no topPri update.
REQ-030 enable=0 in SERVICE SHALL NOT abort; the current grant completes normally.
REQ-031 After any return to IDLE, the next hrq assertion SHALL be no earlier than 2 cycles after the completion cycle.
REQ-032 Inactive dack level = NOT dackSense on every bit; at most one dack bit active at any time.
REQ-033 statusReq SHALL be updated every cycle to effReq.

Reset
REQ-034 On rst=1: state IDLE, hrq=0, grantValid=0, channelNo=0, topPri=0, statusReq=0, dack all inactive; rst overrides every other input, including mid-SERVICE.

Configuration
REQ-035 Macro DMA_ARB_DREQ_SYNC_EN defined: dreq SHALL pass a two-flop synchronizer (reset 0) before REQ-020, adding 2 cycles of latency; undefined: dreq is used directly.

Verification (NUM_CH=4, dreqSense=0, dackSense=0, macro undefined unless stated)
REQ-036 Fixed: dreq=4'b1010, hlda=1 three cycles after hrq -> channelNo=1, dack=4'b1101; release -> then channel 3 served, dack=4'b0111.
REQ-037 Rotating: channel 2 completes, dreq=4'b1111 -> next grant ch3, then ch0, then ch1.
REQ-038 maskRegister=4'b0001, dreq=4'b0001 -> hrq stays 0; requestRegister=4'b0001 -> hrq=1 one cycle later, channelNo=0.
REQ-039 dreq withdrawn in REQ before hlda -> hrq=0 next cycle, dack stays 4'b1111.
REQ-040 rst=1 mid-SERVICE on ch2 with RotatingPriority=1 -> next cycle hrq=0, dack=4'b1111, topPri=0; dreq=4'b1111 afterwards -> ch0 wins.
REQ-041 DREQ rises at cycle 0 -> hrq=1 at cycle 1 without the macro, at cycle 3 with DMA_ARB_DREQ_SYNC_EN.
